mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port `memory` block. It shares the memory between requester A (CPU load/store/fetch) and requester B (program loader / DMA). It runs each access as a fixed three-state sequence, captures read data, and returns a one-cycle acknowledge. Round-robin arbitration guarantees neither requester starves. Out-of-range addresses complete with an error flag and never touch the memory.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port memory.
// Each access runs IDLE -> ACCESS -> RESP and returns a one-cycle ack to the winner.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 1025
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              mem_ce,
    output logic              mem_w,
    output logic              mem_r,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rst,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester raises req with a stable command and holds both
    // until its ack pulse; ack is high for exactly one cycle per accepted request
    // and req is not sampled again until the arbiter is back in IDLE.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            state;
    state_t            state_next;
    logic              last_grant;  // 0 = A, 1 = B
    logic              grant_b;
    logic              any_req;
    logic              cmd_id;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              in_range;
    logic              resp;

    assign any_req  = a_req | b_req;
    // On a tie the port that was not granted last time wins.
    assign grant_b  = b_req & (~a_req | (last_grant == 1'b0));
    assign in_range = ({1'b0, cmd_addr} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cmd_id     <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && any_req) begin
                last_grant <= grant_b;
                cmd_id     <= grant_b;
                cmd_we     <= grant_b ? b_we    : a_we;
                cmd_addr   <= grant_b ? b_addr  : a_addr;
                cmd_wdata  <= grant_b ? b_wdata : a_wdata;
            end
            if (state == S_ACCESS) begin
                err_q   <= ~in_range;
                rdata_q <= (in_range && !cmd_we) ? mem_rdata : '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        mem_ce     = 1'b0;
        mem_w      = 1'b0;
        mem_r      = 1'b0;
        mem_oe     = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) state_next = S_ACCESS;
            end
            S_ACCESS: begin
                // Reset low during ACCESS blocks the memory strobe immediately.
                mem_ce     = in_range & rst;
                mem_w      = cmd_we & in_range & rst;
                mem_r      = ~cmd_we & in_range & rst;
                mem_oe     = ~cmd_we & in_range & rst;
                state_next = S_RESP;
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Command register only changes on entry to ACCESS, so these hold otherwise.
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign mem_rst   = ~rst;

    assign resp    = (state == S_RESP);
    assign a_ack   = resp & ~cmd_id;
    assign b_ack   = resp & cmd_id;
    assign a_rdata = a_ack ? rdata_q : '0;
    assign b_rdata = b_ack ? rdata_q : '0;
    assign a_err   = a_ack & err_q;
    assign b_err   = b_ack & err_q;

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and an expected-response queue.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          a_req, a_we, a_ack, a_err;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_ack, b_err;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_ce, mem_w, mem_r, mem_oe, mem_rst;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem_model [0:1024];
    logic [DW+1:0] exp_q[$];  // {port (1=B), err, rdata}

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(1025)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_ce(mem_ce), .mem_w(mem_w), .mem_r(mem_r), .mem_oe(mem_oe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rst(mem_rst), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory: combinational read, write on the edge.
    assign mem_rdata = (mem_addr < 16'd1025) ? mem_model[mem_addr[10:0]] : '0;
    always @(posedge clk) begin
        if (mem_ce && mem_w && mem_addr < 16'd1025) mem_model[mem_addr[10:0]] <= mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: pop the oldest expected response and compare with the acking port.
    task automatic check_ack();
        logic [DW+1:0] obs;
        logic [DW+1:0] e;
        check("both_ack", 32'(a_ack & b_ack), 32'(0));
        obs = a_ack ? {1'b0, a_err, a_rdata} : {1'b1, b_err, b_rdata};
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ack_resp", 32'(obs), 32'(e));
        end
    endtask

    task automatic wait_ack(output int n, output logic got);
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n++;
            if (a_ack || b_ack) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_timeout", 32'(got), 32'(1));
        if (got) check_ack();
    endtask

    // Driver: one access on a port; reports latency and strobes seen during ACCESS.
    task automatic single_access(input logic port, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                                 input logic exp_err, output int n, output logic ce, output logic w);
        logic got;
        exp_q.push_back({port, exp_err, exp_rdata});
        if (port) begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end
        n = 0; ce = 1'b0; w = 1'b0; got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n++;
            if (dbg_state == 2'd1) begin
                ce = ce | mem_ce;
                w  = w | mem_w;
            end
            if (a_ack || b_ack) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_timeout", 32'(got), 32'(1));
        if (got) check_ack();
        a_req = 1'b0;
        b_req = 1'b0;
        step();
    endtask

    int   n;
    logic ce, w, got;
    int   a_idx, b_idx;

    initial begin
        rst = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        step();
        step();

        // Reset values
        check("rst_outs", 32'({a_ack, a_rdata, a_err, b_ack, b_rdata, b_err}), 32'(0));
        check("rst_mem_ctl", 32'({mem_ce, mem_w, mem_r, mem_oe}), 32'(0));
        check("rst_mem_bus", 32'({mem_addr, mem_wdata}), 32'(0));
        check("rst_mem_rst", 32'(mem_rst), 32'(1));
        check("rst_state", 32'(dbg_state), 32'(0));

        // Request held through reset is ignored, then served after release
        a_we = 1'b1; a_addr = 16'h0030; a_wdata = 8'h77; a_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_hold_ack", 32'(a_ack), 32'(0));
            check("rst_hold_ctl", 32'({mem_ce, mem_w, mem_r, mem_oe}), 32'(0));
        end
        exp_q.push_back({1'b0, 1'b0, 8'h00});
        rst = 1'b1;
        wait_ack(n, got);
        check("rst_release_lat", 32'(n), 32'(2));
        a_req = 1'b0;
        step();

        // Preload via B (program loader)
        single_access(1'b1, 1'b1, 16'h0100, 8'h31, 8'h00, 1'b0, n, ce, w);
        single_access(1'b1, 1'b1, 16'h0101, 8'h32, 8'h00, 1'b0, n, ce, w);
        single_access(1'b1, 1'b1, 16'h0200, 8'h41, 8'h00, 1'b0, n, ce, w);
        single_access(1'b1, 1'b1, 16'h0201, 8'h42, 8'h00, 1'b0, n, ce, w);

        // Single write then read on A
        single_access(1'b0, 1'b1, 16'h0010, 8'h5A, 8'h00, 1'b0, n, ce, w);
        check("wr_lat", 32'(n), 32'(2));
        check("wr_mem_w", 32'(w), 32'(1));
        single_access(1'b0, 1'b0, 16'h0010, 8'h00, 8'h5A, 1'b0, n, ce, w);
        check("rd_lat", 32'(n), 32'(2));
        check("rd_mem_w", 32'(w), 32'(0));
        single_access(1'b0, 1'b0, 16'h0030, 8'h00, 8'h77, 1'b0, n, ce, w);

        // Address boundaries
        single_access(1'b0, 1'b1, 16'h0400, 8'hC3, 8'h00, 1'b0, n, ce, w);
        single_access(1'b0, 1'b0, 16'h0400, 8'h00, 8'hC3, 1'b0, n, ce, w);
        check("last_legal_ce", 32'(ce), 32'(1));
        single_access(1'b0, 1'b0, 16'h0401, 8'h00, 8'h00, 1'b1, n, ce, w);
        check("oor_rd_ce", 32'(ce), 32'(0));
        single_access(1'b1, 1'b1, 16'hFFFF, 8'hEE, 8'h00, 1'b1, n, ce, w);
        check("oor_wr_ce_w", 32'({ce, w}), 32'(0));

        // Reset during ACCESS drops the write and its ack
        single_access(1'b1, 1'b1, 16'h0020, 8'h11, 8'h00, 1'b0, n, ce, w);
        b_we = 1'b1; b_addr = 16'h0020; b_wdata = 8'h99; b_req = 1'b1;
        step();
        check("mid_state", 32'(dbg_state), 32'(1));
        rst = 1'b0;
        #1;
        check("mid_ce_w", 32'({mem_ce, mem_w}), 32'(0));
        step();
        check("mid_no_ack", 32'(b_ack), 32'(0));
        check("mid_idle", 32'(dbg_state), 32'(0));
        b_req = 1'b0;
        rst = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            got = got | a_ack | b_ack;
        end
        check("mid_ack_dropped", 32'(got), 32'(0));
        single_access(1'b0, 1'b0, 16'h0020, 8'h00, 8'h11, 1'b0, n, ce, w);

        // Back-to-back writes on A with req held high
        a_we = 1'b1; a_addr = 16'h0040; a_wdata = 8'hA0; a_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, 1'b0, 8'h00});
            wait_ack(n, got);
            check("b2b_gap", 32'(n), 32'(2));
            step();
            if (i < 2) begin
                a_addr = 16'h0041 + AW'(i);
                a_wdata = 8'hA1 + DW'(i);
            end else begin
                a_req = 1'b0;
            end
        end
        step();
        single_access(1'b0, 1'b0, 16'h0040, 8'h00, 8'hA0, 1'b0, n, ce, w);
        single_access(1'b0, 1'b0, 16'h0041, 8'h00, 8'hA1, 1'b0, n, ce, w);
        single_access(1'b0, 1'b0, 16'h0042, 8'h00, 8'hA2, 1'b0, n, ce, w);

        // Contention after reset: strict A, B, A, B alternation
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 8'h31});
        exp_q.push_back({1'b1, 1'b0, 8'h41});
        exp_q.push_back({1'b0, 1'b0, 8'h32});
        exp_q.push_back({1'b1, 1'b0, 8'h42});
        a_we = 1'b0; a_addr = 16'h0100; a_req = 1'b1;
        b_we = 1'b0; b_addr = 16'h0200; b_req = 1'b1;
        a_idx = 0; b_idx = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(n, got);
            check("cont_gap", 32'(n), 32'(2));
            if (!got) break;
            if (a_ack) a_idx++;
            if (b_ack) b_idx++;
            step();
            if (a_idx >= 2) a_req = 1'b0;
            else a_addr = 16'h0100 + AW'(a_idx);
            if (b_idx >= 2) b_req = 1'b0;
            else b_addr = 16'h0200 + AW'(b_idx);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        step();

        check("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
